// File: rtl/taylor_pkg.sv
// Shared types, order bound and fixed-point helpers for the sequential e^x evaluator.
// Latency: n/a (package only).
// Backpressure: n/a.
package taylor_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFF,
        S_HORNER,
        S_SCALE,
        S_DONE
    } state_t;

    localparam int TAYLOR_MAX_ORDER = 8;
    localparam int ORDER_W          = 4;

    // 2^frac / k!, truncated; evaluated at elaboration to build the coefficient ROM
    function automatic logic [63:0] inv_fact(input int k, input int frac);
        logic [63:0] fact;
        fact = 64'd1;
        for (int i = 2; i <= k; i++) begin
            fact = fact * 64'(i);
        end
        return (64'd1 << frac) / fact;
    endfunction

    function automatic logic add_overflow(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic [ORDER_W-1:0] clamp_order(input logic [ORDER_W-1:0] req,
                                                       input int max_order);
        if (req == '0) begin
            return ORDER_W'(1);
        end else if (int'(req) > max_order) begin
            return ORDER_W'(max_order);
        end
        return req;
    endfunction

endpackage

// File: rtl/taylor_exp_seq_mac.sv
// Combinational fixed-point a*b + c: product truncated toward -inf, W-bit wrap, overflow flagged.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers the result.
module fix_mac_step
    import taylor_pkg::*;
#(
    parameter int W    = 55,
    parameter int FRAC = 23
) (
    input  logic [W-1:0] mul_a,
    input  logic [W-1:0] mul_b,
    input  logic [W-1:0] add_c,
    output logic [W-1:0] res,
    output logic         ovf
);

    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] prod_shr;
    logic [W-1:0]          prod_trunc;
    logic                  mul_ovf;
    logic                  add_ovf;

    assign prod       = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
    assign prod_shr   = prod >>> FRAC;
    assign prod_trunc = prod_shr[W-1:0];

    // Kept word is valid only if everything above it is a copy of its sign bit
    assign mul_ovf = (prod_shr[2*W-1:W] != {W{prod_shr[W-1]}});

    assign res     = prod_trunc + add_c;
    assign add_ovf = add_overflow(prod_trunc[W-1], add_c[W-1], res[W-1]);
    assign ovf     = mul_ovf | add_ovf;

endmodule

// File: rtl/taylor_exp_seq.sv
// Sequential e^x = e^a * sum (x-a)^k/k!, Horner form on one shared multiply-add.
// Latency: result valid N+2 edges after accept; one result per N+4 cycles.
// Backpressure: single evaluation in flight; IN_READY only in IDLE, result held until OUT_READY.
module taylor_exp_seq
    import taylor_pkg::*;
#(
    parameter int NUM_OF_INT  = 32,
    parameter int NUM_OF_FRAC = 23,
    parameter int MAX_ORDER   = TAYLOR_MAX_ORDER
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [ORDER_W-1:0]     IN_ORDER,
    input  logic [NUM_OF_INT-1:0]  IN_X_INT,
    input  logic [NUM_OF_FRAC-1:0] IN_X_FRAC,
    input  logic [NUM_OF_INT-1:0]  IN_A_INT,
    input  logic [NUM_OF_FRAC-1:0] IN_A_FRAC,
    input  logic [NUM_OF_INT-1:0]  IN_EXP_INT,
    input  logic [NUM_OF_FRAC-1:0] IN_EXP_FRAC,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [NUM_OF_INT-1:0]  OUT_EXP_INT,
    output logic [NUM_OF_FRAC-1:0] OUT_EXP_FRAC,
    output logic                   OUT_OVF
);

    localparam int W       = NUM_OF_INT + NUM_OF_FRAC;
    localparam int NUM_COEF = 1 << ORDER_W;

    state_t state;
    state_t state_nxt;

    logic [W-1:0]       x_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       ea_r;
    logic [W-1:0]       d_r;
    logic [W-1:0]       acc_r;
    logic [ORDER_W-1:0] n_r;
    logic [ORDER_W-1:0] k_r;
    logic               ovf_r;
    logic [W-1:0]       out_exp_r;
    logic               out_ovf_r;

    logic [W-1:0]       mac_b;
    logic [W-1:0]       mac_c;
    logic [W-1:0]       mac_res;
    logic               mac_ovf;

    // Entries above MAX_ORDER are never selected after the order clamp
    logic [W-1:0] coef [0:NUM_COEF-1];
    for (genvar i = 0; i < NUM_COEF; i++) begin : g_coef
        assign coef[i] = (i <= MAX_ORDER) ? W'(inv_fact(i, NUM_OF_FRAC)) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (IN_VALID) state_nxt = S_DIFF;
            S_DIFF:   state_nxt = S_HORNER;
            S_HORNER: if (k_r == '0) state_nxt = S_SCALE;
            S_SCALE:  state_nxt = S_DONE;
            S_DONE:   if (OUT_READY) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The one multiply-add serves Horner steps (c = C[k]) and the final e^a scale (c = 0)
    assign mac_b = (state == S_SCALE) ? ea_r : d_r;
    assign mac_c = (state == S_SCALE) ? '0 : coef[k_r];

    fix_mac_step #(
        .W    (W),
        .FRAC (NUM_OF_FRAC)
    ) u_mac (
        .mul_a (acc_r),
        .mul_b (mac_b),
        .add_c (mac_c),
        .res   (mac_res),
        .ovf   (mac_ovf)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            x_r       <= '0;
            a_r       <= '0;
            ea_r      <= '0;
            d_r       <= '0;
            acc_r     <= '0;
            n_r       <= '0;
            k_r       <= '0;
            ovf_r     <= 1'b0;
            out_exp_r <= '0;
            out_ovf_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        x_r   <= {IN_X_INT, IN_X_FRAC};
                        a_r   <= {IN_A_INT, IN_A_FRAC};
                        ea_r  <= {IN_EXP_INT, IN_EXP_FRAC};
                        n_r   <= clamp_order(IN_ORDER, MAX_ORDER);
                        ovf_r <= 1'b0;
                    end
                end
                S_DIFF: begin
                    d_r   <= x_r + (~a_r + W'(1));
                    acc_r <= coef[n_r];
                    k_r   <= n_r - ORDER_W'(1);
                end
                S_HORNER: begin
                    acc_r <= mac_res;
                    ovf_r <= ovf_r | mac_ovf;
                    if (k_r != '0) begin
                        k_r <= k_r - ORDER_W'(1);
                    end
                end
                S_SCALE: begin
                    out_exp_r <= mac_res;
                    out_ovf_r <= ovf_r | mac_ovf;
                end
                default: ;
            endcase
        end
    end

    assign IN_READY     = (state == S_IDLE);
    assign OUT_VALID    = (state == S_DONE);
    assign OUT_EXP_INT  = out_exp_r[W-1:NUM_OF_FRAC];
    assign OUT_EXP_FRAC = out_exp_r[NUM_OF_FRAC-1:0];
    assign OUT_OVF      = out_ovf_r;

endmodule

// File: tb/tb_taylor_exp_seq.sv
// Scoreboard bench for taylor_exp_seq: expectations queued on drive, checked when a result appears.
module tb_taylor_exp_seq;

    localparam int NI = 32;
    localparam int NF = 23;
    localparam int W  = NI + NF;

    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = 55'd8388608;
    localparam logic [W-1:0] HALF = 55'd4194304;
    localparam logic [W-1:0] TWO  = 55'd16777216;
    localparam logic [W-1:0] BIG  = 55'd1 << 53;   // 2^30 in fixed point

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [3:0]    IN_ORDER = '0;
    logic [NI-1:0] IN_X_INT = '0;
    logic [NF-1:0] IN_X_FRAC = '0;
    logic [NI-1:0] IN_A_INT = '0;
    logic [NF-1:0] IN_A_FRAC = '0;
    logic [NI-1:0] IN_EXP_INT = '0;
    logic [NF-1:0] IN_EXP_FRAC = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [NI-1:0] OUT_EXP_INT;
    logic [NF-1:0] OUT_EXP_FRAC;
    logic          OUT_OVF;

    taylor_exp_seq #(
        .NUM_OF_INT  (NI),
        .NUM_OF_FRAC (NF),
        .MAX_ORDER   (8)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_ORDER     (IN_ORDER),
        .IN_X_INT     (IN_X_INT),
        .IN_X_FRAC    (IN_X_FRAC),
        .IN_A_INT     (IN_A_INT),
        .IN_A_FRAC    (IN_A_FRAC),
        .IN_EXP_INT   (IN_EXP_INT),
        .IN_EXP_FRAC  (IN_EXP_FRAC),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .OUT_EXP_INT  (OUT_EXP_INT),
        .OUT_EXP_FRAC (OUT_EXP_FRAC),
        .OUT_OVF      (OUT_OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] val;
        logic         ovf;
        int           lat;
        int           tol;
        bit           chk_val;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    function automatic exp_t mk(input logic [W-1:0] val, input logic ovf, input int lat,
                                input int tol, input bit chk_val);
        exp_t e;
        e.val = val;
        e.ovf = ovf;
        e.lat = lat;
        e.tol = tol;
        e.chk_val = chk_val;
        return e;
    endfunction

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] a, input logic [W-1:0] ea,
                         input logic [3:0] ord);
        int guard;
        guard = 0;
        @(negedge CLK);
        while (!IN_READY && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        chk("in_rdy_before_send", IN_READY, 1);
        {IN_X_INT, IN_X_FRAC}     = x;
        {IN_A_INT, IN_A_FRAC}     = a;
        {IN_EXP_INT, IN_EXP_FRAC} = ea;
        IN_ORDER = ord;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] a,
                      input logic [W-1:0] ea, input logic [3:0] ord, input exp_t e,
                      input int hold);
        exp_t         got;
        int           lat;
        longint       diff;
        logic [W-1:0] obs;
        logic [W-1:0] held;
        logic         held_ovf;
        sb.push_back(e);
        drive(x, a, ea, ord);
        lat = 0;
        while (!OUT_VALID && lat < 40) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        got = sb.pop_front();
        obs = {OUT_EXP_INT, OUT_EXP_FRAC};
        chk({tag, "_valid"}, OUT_VALID, 1);
        chk({tag, "_lat"}, lat, got.lat);
        if (got.chk_val) begin
            if (got.tol == 0) begin
                chk({tag, "_val"}, obs, got.val);
            end else begin
                diff = longint'(obs) - longint'(got.val);
                if (diff < 0) diff = -diff;
                chk({tag, "_val_tol"}, (diff <= longint'(got.tol)), 1);
            end
        end
        chk({tag, "_ovf"}, OUT_OVF, got.ovf);
        held     = obs;
        held_ovf = OUT_OVF;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            #1;
            chk({tag, "_hold_valid"}, OUT_VALID, 1);
            chk({tag, "_hold_inrdy"}, IN_READY, 0);
            chk({tag, "_hold_val"}, {OUT_EXP_INT, OUT_EXP_FRAC}, held);
            chk({tag, "_hold_ovf"}, OUT_OVF, held_ovf);
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk({tag, "_drop"}, OUT_VALID, 0);
        chk({tag, "_inrdy_after"}, IN_READY, 1);
        chk({tag, "_retain"}, {OUT_EXP_INT, OUT_EXP_FRAC}, held);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_rdy", IN_READY, 1);
        chk("rst_out_vld", OUT_VALID, 0);
        chk("rst_out_exp", {OUT_EXP_INT, OUT_EXP_FRAC}, 0);
        chk("rst_out_ovf", OUT_OVF, 0);
        @(negedge CLK);
        RST = 1'b0;

        op("x0_n6",   ZERO, ZERO, ONE, 4'd6,  mk(ONE,          1'b0, 8,  0, 1'b1), 0);
        op("xh_n2",   HALF, ZERO, ONE, 4'd2,  mk(55'd13631488, 1'b0, 4,  0, 1'b1), 0);
        op("xh_n1",   HALF, ZERO, ONE, 4'd1,  mk(55'd12582912, 1'b0, 3,  0, 1'b1), 0);
        op("negd_n2", ZERO, ONE,  ONE, 4'd2,  mk(HALF,         1'b0, 4,  0, 1'b1), 0);
        op("clamp0",  HALF, ZERO, ONE, 4'd0,  mk(55'd12582912, 1'b0, 3,  0, 1'b1), 0);
        op("clamp15", HALF, ZERO, ONE, 4'd15, mk(55'd13830477, 1'b0, 10, 2, 1'b1), 0);
        op("hold5",   HALF, ZERO, ONE, 4'd2,  mk(55'd13631488, 1'b0, 4,  0, 1'b1), 5);

        // Abort an evaluation while it is iterating Horner steps
        drive(HALF, ZERO, ONE, 4'd8);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst_in_rdy", IN_READY, 1);
        chk("midrst_out_vld", OUT_VALID, 0);
        chk("midrst_out_exp", {OUT_EXP_INT, OUT_EXP_FRAC}, 0);
        chk("midrst_out_ovf", OUT_OVF, 0);
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (OUT_VALID) seen++;
        end
        chk("midrst_no_result", seen, 0);

        op("post_rst_n3", HALF, ZERO, ONE, 4'd3, mk(55'd13806250, 1'b0, 5,  0, 1'b1), 0);
        op("ovf_scale",   TWO,  ZERO, BIG, 4'd8, mk(ZERO,          1'b1, 10, 0, 1'b0), 0);
        op("ovf_cleared", ZERO, ZERO, ONE, 4'd6, mk(ONE,           1'b0, 8,  0, 1'b1), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
